// File: rtl/graphics_type_pkg.sv
`default_nettype none
// ============================================================================
// Module      : graphics_type_pkg
// Description : Shared geometry types for the scene-object and triangle setup
//               blocks: model vertices, indexed triangles, 4:4:4 color and
//               screen-space triangles. Also holds the setup FSM encoding and
//               the screen-space signed area helper.
// Revision    : 1.0 - initial release
// ============================================================================
package graphics_type_pkg;

    // Screen origin and fixed-point format of the sin/cos inputs
    localparam int SCREEN_CX = 320;
    localparam int SCREEN_CY = 240;
    localparam int Q_FRAC    = 8;

    // Field widths
    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 11;
    localparam int VIDX_W   = 4;
    localparam int TIDX_W   = 4;
    localparam int AREA_W   = 23;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } color_t;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } vertex_3d_t;

    // Vertex indices are one bit wider than needed for 8 vertices so that
    // out-of-range references can be represented and detected.
    typedef struct packed {
        logic [VIDX_W-1:0] v0;
        logic [VIDX_W-1:0] v1;
        logic [VIDX_W-1:0] v2;
        color_t            color;
    } triangle_t;

    typedef struct packed {
        logic signed [SCREEN_W-1:0] x;
        logic signed [SCREEN_W-1:0] y;
    } screen_vertex_t;

    typedef struct packed {
        screen_vertex_t [0:2] v;
        color_t               color;
        logic [TIDX_W-1:0]    idx;
    } screen_triangle_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_XFORM0 = 3'd2,
        ST_XFORM1 = 3'd3,
        ST_XFORM2 = 3'd4,
        ST_CULL   = 3'd5,
        ST_EMIT   = 3'd6,
        ST_DONE   = 3'd7
    } tse_state_t;

    // Twice the signed screen-space area; negative means the winding faces
    // the viewer (screen Y grows downward).
    function automatic logic signed [AREA_W-1:0] tri_area(
        input screen_vertex_t a,
        input screen_vertex_t b,
        input screen_vertex_t c
    );
        logic signed [AREA_W-1:0] dx1;
        logic signed [AREA_W-1:0] dy1;
        logic signed [AREA_W-1:0] dx2;
        logic signed [AREA_W-1:0] dy2;
        dx1 = AREA_W'(b.x) - AREA_W'(a.x);
        dy1 = AREA_W'(b.y) - AREA_W'(a.y);
        dx2 = AREA_W'(c.x) - AREA_W'(a.x);
        dy2 = AREA_W'(c.y) - AREA_W'(a.y);
        return (dx1 * dy2) - (dx2 * dy1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tri_setup_engine_rotate.sv
`default_nettype none
// ============================================================================
// Module      : vertex_rotate_y
// Description : Combinational Y-axis rotation of one model vertex followed by
//               orthographic projection to screen space.
// Revision    : 1.0 - initial release
// ============================================================================
module vertex_rotate_y
    import graphics_type_pkg::*;
#(
    parameter int CENTER_X = SCREEN_CX,
    parameter int CENTER_Y = SCREEN_CY
) (
    input  vertex_3d_t         i_vertex,
    input  logic signed [9:0]  i_cos,
    input  logic signed [9:0]  i_sin,
    output screen_vertex_t     o_screen
);

    logic signed [19:0] w_prod_x;
    logic signed [19:0] w_prod_z;
    logic signed [20:0] w_sum;

    // Q1.8 products; the 21-bit sum cannot overflow for 10-bit operands
    assign w_prod_x = i_vertex.x * i_cos;
    assign w_prod_z = i_vertex.z * i_sin;
    assign w_sum    = 21'(w_prod_x) + 21'(w_prod_z);

    // Screen Y grows downward, so model Y is subtracted from the centre
    assign o_screen.x = 11'(21'(CENTER_X) + (w_sum >>> Q_FRAC));
    assign o_screen.y = 11'(11'(CENTER_Y) - 11'(i_vertex.y));

endmodule
`default_nettype wire

// File: rtl/tri_setup_engine.sv
`default_nettype none
// ============================================================================
// Module      : tri_setup_engine
// Description : Walks the triangle list once per start, rotates each vertex
//               about Y, projects to screen space, back-face culls and emits
//               surviving triangles over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_setup_engine
    import graphics_type_pkg::*;
#(
    parameter int NUM_VERTS = 8,
    parameter int NUM_TRIS  = 12,
    parameter int CENTER_X  = SCREEN_CX,
    parameter int CENTER_Y  = SCREEN_CY,
    parameter bit CULL_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic signed [9:0] cos_q,
    input  logic signed [9:0] sin_q,
    input  vertex_3d_t        vertices  [0:NUM_VERTS-1],
    input  triangle_t         triangles [0:NUM_TRIS-1],
    output logic              out_valid,
    input  logic              out_ready,
    output screen_triangle_t  out_tri,
    output logic              busy,
    output logic              done
);

    localparam int VSEL_W = $clog2(NUM_VERTS);
    localparam logic [TIDX_W-1:0] C_LAST_IDX = TIDX_W'(NUM_TRIS - 1);

    tse_state_t           r_state_q,     w_state_d;
    logic [TIDX_W-1:0]    r_idx_q,       w_idx_d;
    triangle_t            r_tri_q,       w_tri_d;
    logic signed [9:0]    r_cos_q,       w_cos_d;
    logic signed [9:0]    r_sin_q,       w_sin_d;
    screen_vertex_t [0:2] r_sv_q,        w_sv_d;
    logic                 r_out_valid_q, w_out_valid_d;
    screen_triangle_t     r_out_tri_q,   w_out_tri_d;
    logic                 r_busy_q,      w_busy_d;
    logic                 r_done_q,      w_done_d;

    logic [VIDX_W-1:0]        w_vidx;
    vertex_3d_t               w_vtx;
    screen_vertex_t           w_rot;
    logic signed [AREA_W-1:0] w_area;
    logic                     w_keep;
    logic                     w_last;

    // Pick the vertex index for the transform step currently in progress
    always_comb begin
        w_vidx = r_tri_q.v0;
        case (r_state_q)
            ST_XFORM1: w_vidx = r_tri_q.v1;
            ST_XFORM2: w_vidx = r_tri_q.v2;
            default:   w_vidx = r_tri_q.v0;
        endcase
    end

    // Out-of-range indices read as the origin rather than aliasing a vertex
    assign w_vtx = ({1'b0, w_vidx} < (VIDX_W + 1)'(NUM_VERTS)) ?
                   vertices[w_vidx[VSEL_W-1:0]] : '0;

    vertex_rotate_y #(
        .CENTER_X (CENTER_X),
        .CENTER_Y (CENTER_Y)
    ) u_rotate (
        .i_vertex (w_vtx),
        .i_cos    (r_cos_q),
        .i_sin    (r_sin_q),
        .o_screen (w_rot)
    );

    assign w_area = tri_area(r_sv_q[0], r_sv_q[1], r_sv_q[2]);
    assign w_keep = !CULL_EN || (w_area < AREA_W'(0));
    assign w_last = (r_idx_q == C_LAST_IDX);

    // Next-state and datapath update for the per-triangle sequence
    always_comb begin
        w_state_d     = r_state_q;
        w_idx_d       = r_idx_q;
        w_tri_d       = r_tri_q;
        w_cos_d       = r_cos_q;
        w_sin_d       = r_sin_q;
        w_sv_d        = r_sv_q;
        w_out_valid_d = r_out_valid_q;
        w_out_tri_d   = r_out_tri_q;
        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_state_d = ST_FETCH;
                    w_idx_d   = '0;
                    w_cos_d   = cos_q;
                    w_sin_d   = sin_q;
                end
            end
            ST_FETCH: begin
                w_tri_d   = triangles[r_idx_q];
                w_state_d = ST_XFORM0;
            end
            ST_XFORM0: begin
                w_sv_d[0] = w_rot;
                w_state_d = ST_XFORM1;
            end
            ST_XFORM1: begin
                w_sv_d[1] = w_rot;
                w_state_d = ST_XFORM2;
            end
            ST_XFORM2: begin
                w_sv_d[2] = w_rot;
                w_state_d = ST_CULL;
            end
            ST_CULL: begin
                if (w_keep) begin
                    w_out_tri_d.v     = r_sv_q;
                    w_out_tri_d.color = r_tri_q.color;
                    w_out_tri_d.idx   = r_idx_q;
                    w_out_valid_d     = 1'b1;
                    w_state_d         = ST_EMIT;
                end else if (w_last) begin
                    w_state_d = ST_DONE;
                end else begin
                    w_idx_d   = r_idx_q + TIDX_W'(1);
                    w_state_d = ST_FETCH;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    w_out_valid_d = 1'b0;
                    if (w_last) begin
                        w_state_d = ST_DONE;
                    end else begin
                        w_idx_d   = r_idx_q + TIDX_W'(1);
                        w_state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
        w_busy_d = (w_state_d != ST_IDLE);
        w_done_d = (w_state_d == ST_DONE);
    end

    // State and registered outputs; reset abandons any in-flight triangle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_idx_q       <= '0;
            r_tri_q       <= '0;
            r_cos_q       <= '0;
            r_sin_q       <= '0;
            r_sv_q        <= '0;
            r_out_valid_q <= 1'b0;
            r_out_tri_q   <= '0;
            r_busy_q      <= 1'b0;
            r_done_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_idx_q       <= w_idx_d;
            r_tri_q       <= w_tri_d;
            r_cos_q       <= w_cos_d;
            r_sin_q       <= w_sin_d;
            r_sv_q        <= w_sv_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_tri_q   <= w_out_tri_d;
            r_busy_q      <= w_busy_d;
            r_done_q      <= w_done_d;
        end
    end

    assign out_valid = r_out_valid_q;
    assign out_tri   = r_out_tri_q;
    assign busy      = r_busy_q;
    assign done      = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_tri_setup_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_tri_setup_engine
// Description : Directed self-checking bench for tri_setup_engine using an
//               axis-aligned cube of half-size 80 with hand-derived results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tri_setup_engine;
    import graphics_type_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              start_nc;
    logic signed [9:0] cos_q;
    logic signed [9:0] sin_q;
    vertex_3d_t        verts [0:7];
    triangle_t         tris  [0:11];
    logic              out_ready;
    logic              out_ready_nc;
    logic              out_valid,  out_valid_nc;
    screen_triangle_t  out_tri,    out_tri_nc;
    logic              busy,       busy_nc;
    logic              done,       done_nc;

    int                n_checks = 0;
    int                n_err    = 0;
    screen_triangle_t  q_tri [$];
    logic [3:0]        q_idx [$];
    int                nd;
    logic              busy_late;
    screen_triangle_t  e0, e1, e8, e9;

    always #5 clk = ~clk;

    tri_setup_engine #(.CULL_EN(1'b1)) u_dut (
        .clk (clk), .rst (rst), .start (start), .cos_q (cos_q), .sin_q (sin_q),
        .vertices (verts), .triangles (tris), .out_valid (out_valid),
        .out_ready (out_ready), .out_tri (out_tri), .busy (busy), .done (done)
    );

    tri_setup_engine #(.CULL_EN(1'b0)) u_dut_nc (
        .clk (clk), .rst (rst), .start (start_nc), .cos_q (cos_q), .sin_q (sin_q),
        .vertices (verts), .triangles (tris), .out_valid (out_valid_nc),
        .out_ready (out_ready_nc), .out_tri (out_tri_nc), .busy (busy_nc), .done (done_nc)
    );

    function automatic vertex_3d_t mkv(input int x, input int y, input int z);
        vertex_3d_t v;
        v.x = 10'(x); v.y = 10'(y); v.z = 10'(z);
        return v;
    endfunction

    function automatic triangle_t mkt(input int a, input int b, input int c, input logic [11:0] col);
        triangle_t t;
        t.v0 = 4'(a); t.v1 = 4'(b); t.v2 = 4'(c); t.color = col;
        return t;
    endfunction

    function automatic screen_triangle_t mks(input int x0, input int y0, input int x1, input int y1,
                                             input int x2, input int y2, input logic [11:0] col, input int idx);
        screen_triangle_t s;
        s.v[0].x = 11'(x0); s.v[0].y = 11'(y0);
        s.v[1].x = 11'(x1); s.v[1].y = 11'(y1);
        s.v[2].x = 11'(x2); s.v[2].y = 11'(y2);
        s.color  = col;
        s.idx    = 4'(idx);
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tri(input string tag, input screen_triangle_t obs, input screen_triangle_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Record handshakes and done pulses until 8 cycles after the first done;
    // optionally pokes start in the done cycle, which must be ignored.
    task automatic collect(input int budget, input bit poke);
        int tail;
        tail = -1;
        q_tri.delete();
        nd = 0;
        busy_late = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (out_valid && out_ready) q_tri.push_back(out_tri);
            if (done) begin
                nd++;
                if (tail < 0) tail = c;
                if (poke) start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            if (tail >= 0 && busy) busy_late = 1'b1;
            if (tail >= 0 && c >= tail + 8) break;
        end
    endtask

    task automatic chk_two(input string tag, input screen_triangle_t a, input screen_triangle_t b);
        chk({tag, "_count"}, 32'(q_tri.size()), 32'd2);
        if (q_tri.size() >= 1) chk_tri({tag, "_t0"}, q_tri[0], a);
        if (q_tri.size() >= 2) chk_tri({tag, "_t1"}, q_tri[1], b);
        chk({tag, "_done"}, 32'(nd), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; start_nc = 1'b0;
        cos_q = 10'sd256; sin_q = 10'sd0;
        out_ready = 1'b1; out_ready_nc = 1'b1;

        verts[0] = mkv( 80,  80, -80);  verts[1] = mkv(-80,  80, -80);
        verts[2] = mkv(-80, -80, -80);  verts[3] = mkv( 80, -80, -80);
        verts[4] = mkv( 80,  80,  80);  verts[5] = mkv(-80,  80,  80);
        verts[6] = mkv(-80, -80,  80);  verts[7] = mkv( 80, -80,  80);
        tris[0]  = mkt(0, 1, 2, 12'hF00); tris[1]  = mkt(0, 2, 3, 12'hF00);
        tris[2]  = mkt(4, 6, 5, 12'h0F0); tris[3]  = mkt(4, 7, 6, 12'h0F0);
        tris[4]  = mkt(0, 1, 5, 12'h00F); tris[5]  = mkt(0, 5, 4, 12'h00F);
        tris[6]  = mkt(2, 3, 7, 12'hFF0); tris[7]  = mkt(2, 7, 6, 12'hFF0);
        tris[8]  = mkt(4, 0, 3, 12'h0FF); tris[9]  = mkt(4, 3, 7, 12'h0FF);
        tris[10] = mkt(5, 2, 1, 12'hF0F); tris[11] = mkt(5, 6, 2, 12'hF0F);

        e0 = mks(400, 160, 240, 160, 240, 320, 12'hF00, 0);
        e1 = mks(400, 160, 240, 320, 400, 320, 12'hF00, 1);
        e8 = mks(400, 160, 240, 160, 240, 320, 12'h0FF, 8);
        e9 = mks(400, 160, 240, 320, 400, 320, 12'h0FF, 9);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk_tri("rst_tri", out_tri, '0);
        rst = 1'b0;

        // Identity rotation; a start in the done cycle must not restart
        do_start();
        chk("id_busy", 32'(busy), 32'd1);
        collect(400, 1'b1);
        chk_two("id", e0, e1);
        chk("id_start_at_done_ignored", 32'(busy_late), 32'd0);

        // 90 degree rotation exposes the +X face
        cos_q = 10'sd0; sin_q = 10'sd256;
        do_start();
        collect(400, 1'b0);
        chk_two("rot90", e8, e9);
        cos_q = 10'sd256; sin_q = 10'sd0;

        // Culling disabled: all 12 in order, first valid 6 edges after start
        @(negedge clk); start_nc = 1'b1;
        @(negedge clk); start_nc = 1'b0;
        n = 1;
        while (!out_valid_nc && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("nc_latency", 32'(n), 32'd6);
        chk_tri("nc_first", out_tri_nc, e0);
        q_idx.delete();
        nd = 0;
        for (int c = 0; c < 300; c++) begin
            if (out_valid_nc && out_ready_nc) q_idx.push_back(out_tri_nc.idx);
            if (done_nc) nd++;
            @(negedge clk);
            if (nd > 0 && !busy_nc && c > 80) break;
        end
        repeat (8) begin
            @(negedge clk);
            if (done_nc) nd++;
        end
        chk("nc_count", 32'(q_idx.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < q_idx.size()) chk($sformatf("nc_idx%0d", i), 32'(q_idx[i]), 32'(i));
        end
        chk("nc_done", 32'(nd), 32'd1);

        // Backpressure: hold ready low for 3 cycles at the first emit
        out_ready = 1'b0;
        do_start();
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid0", 32'(out_valid), 32'd1);
        chk_tri("bp_tri0", out_tri, e0);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
            chk_tri($sformatf("bp_tri%0d", k), out_tri, e0);
        end
        out_ready = 1'b1;
        collect(400, 1'b0);
        chk_two("bp", e0, e1);

        // Second start while busy and sin changed mid-pass: no effect
        do_start();
        @(negedge clk);
        start = 1'b1; sin_q = 10'sd256;
        @(negedge clk);
        start = 1'b0;
        collect(400, 1'b0);
        chk_two("restart", e0, e1);
        sin_q = 10'sd0;

        // Reset during XFORM1 of triangle 1, then a clean pass
        do_start();
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_done",  32'(done),      32'd0);
        rst = 1'b0;
        do_start();
        collect(400, 1'b0);
        chk_two("post_rst", e0, e1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
